// File: rtl/vram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared types and constants for the video RAM arbiter:
//   grant_state_t : grant FSM encoding (S_IDLE, S_DISP, S_HOST)
//   rd_tag_t      : read-return tag (TAG_NONE, TAG_DISP, TAG_HOST)
//   CNT_W         : width of the wait and conflict counters
//   WAIT_MAX_DEF  : default host starvation threshold
//   sat_inc       : saturating increment for CNT_W-wide counters
// ---------------------------------------------------------------------------
package vram_arbiter_pkg;

    localparam int CNT_W        = 16;
    localparam int WAIT_MAX_DEF = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_HOST = 2'd2
    } grant_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } rd_tag_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the display port, host port, statistics and RAM command/return
// signals of the arbiter.
//   modport master : the arbiter's view (takes requests and RAM read data,
//                    drives responses and RAM commands)
//   slave          : the environment's view (requesters plus RAM)
// Handshake: disp_req is a per-cycle request, one word per asserted cycle;
// host_req is held until host_ack pulses, and host_ack means the command
// has been issued to RAM in that same cycle. Read data comes back as a
// one-cycle valid pulse with data held between pulses.
// ---------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    // display scan-out port
    logic                                 disp_req;
    logic [ADDR_W-1:0]                    disp_addr;
    logic [DATA_W-1:0]                    disp_data;
    logic                                 disp_valid;
    // host port
    logic                                 host_req;
    logic                                 host_we;
    logic [ADDR_W-1:0]                    host_addr;
    logic [DATA_W-1:0]                    host_wdata;
    logic                                 host_ack;
    logic [DATA_W-1:0]                    host_rdata;
    logic                                 host_rvalid;
    logic                                 host_starve;
    // statistics
    logic                                 stat_clr;
    logic [vram_arbiter_pkg::CNT_W-1:0]   stat_conflict;
    // synchronous single-port RAM
    logic                                 ram_ce;
    logic                                 ram_we;
    logic [ADDR_W-1:0]                    ram_addr;
    logic [DATA_W-1:0]                    ram_wdata;
    logic [DATA_W-1:0]                    ram_rdata;

    modport master (
        input  disp_req, disp_addr, host_req, host_we, host_addr, host_wdata,
               stat_clr, ram_rdata,
        output disp_data, disp_valid, host_ack, host_rdata, host_rvalid,
               host_starve, stat_conflict, ram_ce, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output disp_req, disp_addr, host_req, host_we, host_addr, host_wdata,
               stat_clr, ram_rdata,
        input  disp_data, disp_valid, host_ack, host_rdata, host_rvalid,
               host_starve, stat_conflict, ram_ce, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/vram_arb_rdpipe.sv
// ---------------------------------------------------------------------------
// vram_arb_rdpipe
// Carries the read tag of each issued command alongside the RAM access and
// steers RAM read data to the display or host output.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_tag          : tag of the command being decided this cycle
//   i_ram_rdata    : RAM read data (valid two cycles after the decision)
//   o_disp_data/o_disp_valid   : display return, data held between pulses
//   o_host_rdata/o_host_rvalid : host return, data held between pulses
// Stage 1 lines up with the registered RAM command, stage 2 with the RAM
// read data; the output registers make the total latency three cycles.
// ---------------------------------------------------------------------------
module vram_arb_rdpipe
    import vram_arbiter_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  rd_tag_t           i_tag,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_disp_data,
    output logic              o_disp_valid,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_host_rvalid
);

    rd_tag_t           r_tag_s1;
    rd_tag_t           r_tag_s2;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_host_rdata;
    logic              r_host_rvalid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Flushing both tag stages drops any read in flight, so no
            // valid pulse can appear after reset.
            r_tag_s1      <= TAG_NONE;
            r_tag_s2      <= TAG_NONE;
            r_disp_data   <= '0;
            r_disp_valid  <= 1'b0;
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_tag_s1      <= i_tag;
            r_tag_s2      <= r_tag_s1;
            r_disp_valid  <= (r_tag_s2 == TAG_DISP);
            r_host_rvalid <= (r_tag_s2 == TAG_HOST);
            if (r_tag_s2 == TAG_DISP) begin
                r_disp_data <= i_ram_rdata;
            end
            if (r_tag_s2 == TAG_HOST) begin
                r_host_rdata <= i_ram_rdata;
            end
        end
    end

    assign o_disp_data   = r_disp_data;
    assign o_disp_valid  = r_disp_valid;
    assign o_host_rdata  = r_host_rdata;
    assign o_host_rvalid = r_host_rvalid;

endmodule

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Single-port video RAM arbiter. Display fetches always win; the host is
// served in any cycle without a display fetch, except the cycle in which
// host_ack is high, so a held host_req cannot issue twice.
//   i_clk        : system clock
//   i_rst        : synchronous active-high reset
//   bus          : vram_arbiter_if.master (display, host, stats, RAM)
//   o_dbg_state  : current grant state (command being issued to RAM)
// Timing: request at t, RAM command and host_ack at t+1, RAM data at t+2,
// valid pulse and data at t+3.
// Optional feature: define VRAM_ARB_STATS_EN to build the 16-bit conflict
// counter; otherwise stat_conflict is tied to zero and stat_clr is ignored.
// ---------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    vram_arbiter_if.master bus,
    output grant_state_t  o_dbg_state
);

    localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(WAIT_MAX);

    grant_state_t      r_state;
    logic              r_ram_ce;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_host_ack;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic              w_grant_disp;
    logic              w_grant_host;
    rd_tag_t           w_issue_tag;

    // Grant decision for the current cycle. The r_host_ack term is the
    // turnaround: the requester only sees its ack now, so its request
    // is still up and must not be granted again.
    assign w_grant_disp = bus.disp_req;
    assign w_grant_host = !bus.disp_req && bus.host_req && !r_host_ack;

    // Host writes return nothing, so they carry no tag.
    assign w_issue_tag = w_grant_disp                  ? TAG_DISP :
                         (w_grant_host && !bus.host_we) ? TAG_HOST :
                                                          TAG_NONE;

    // Grant FSM with registered RAM command and host_ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ram_ce    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_host_ack  <= 1'b0;
        end else if (w_grant_disp) begin
            r_state     <= S_DISP;
            r_ram_ce    <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= bus.disp_addr;
            r_host_ack  <= 1'b0;
        end else if (w_grant_host) begin
            r_state     <= S_HOST;
            r_ram_ce    <= 1'b1;
            r_ram_we    <= bus.host_we;
            r_ram_addr  <= bus.host_addr;
            r_ram_wdata <= bus.host_wdata;
            r_host_ack  <= 1'b1;
        end else begin
            r_state     <= S_IDLE;
            r_ram_ce    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_host_ack  <= 1'b0;
        end
    end

    // Consecutive cycles the host has been kept waiting. The ack
    // turnaround cycle counts as waiting if the request is still held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
        end else if (!bus.host_req || w_grant_host) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= sat_inc(r_wait_cnt);
        end
    end

    vram_arb_rdpipe #(
        .DATA_W (DATA_W)
    ) u_rdpipe (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_tag         (w_issue_tag),
        .i_ram_rdata   (bus.ram_rdata),
        .o_disp_data   (bus.disp_data),
        .o_disp_valid  (bus.disp_valid),
        .o_host_rdata  (bus.host_rdata),
        .o_host_rvalid (bus.host_rvalid)
    );

`ifdef VRAM_ARB_STATS_EN
    logic [CNT_W-1:0] r_stat_conflict;

    // Clear wins over a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_conflict <= '0;
        end else if (bus.stat_clr) begin
            r_stat_conflict <= '0;
        end else if (bus.disp_req && bus.host_req) begin
            r_stat_conflict <= sat_inc(r_stat_conflict);
        end
    end

    assign bus.stat_conflict = r_stat_conflict;
`else
    logic w_unused_stat_clr;

    assign w_unused_stat_clr = bus.stat_clr;
    assign bus.stat_conflict = '0;
`endif

    assign bus.ram_ce      = r_ram_ce;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wdata   = r_ram_wdata;
    assign bus.host_ack    = r_host_ack;
    assign bus.host_starve = (r_wait_cnt >= WAIT_MAX_C);
    assign o_dbg_state     = r_state;

endmodule
